// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer: multi-channel PWM brightness gate with immediate or
// timed-fade level updates. Each channel passes its input pattern while its
// PWM phase is on and substitutes its blank pattern while off.
module led_pwm_dimmer #(
    parameter int CHANNELS     = 5,
    parameter int DATA_W       = 8,
    parameter int PWM_BITS     = 4,
    parameter int SEL_W        = 3,
    parameter int FADE_PERIODS = 4,
    parameter logic [CHANNELS*DATA_W-1:0] BLANK = {CHANNELS*DATA_W{1'b1}}
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cs,
    input  logic                         level_we,
    input  logic [SEL_W-1:0]             level_sel,
    input  logic [PWM_BITS-1:0]          level_in,
    input  logic                         mode,
    input  logic [CHANNELS*DATA_W-1:0]   data_in,
    output logic [CHANNELS*DATA_W-1:0]   data_out,
    output logic                         period_start,
    output logic                         fade_busy
);

    localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
    localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_PERIODS - 1);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FADE_W-1:0]   fade_cnt;
    logic [PWM_BITS-1:0] level  [CHANNELS];
    logic [PWM_BITS-1:0] target [CHANNELS];

    logic [CHANNELS-1:0] on;
    logic [CHANNELS-1:0] busy_ch;
    logic [CHANNELS-1:0] wr_hit;
    logic                period_end;
    logic                tick;
    logic                wr_en;

    assign period_end   = (pwm_cnt == PWM_MAX);
    assign tick         = period_end && (fade_cnt == FADE_LAST);
    assign wr_en        = cs && level_we;
    assign period_start = (pwm_cnt == '0);
    assign fade_busy    = |busy_ch;

    // Per-channel decode: PWM on-phase, fade pending, and write select.
    // A select at or beyond CHANNELS matches no channel, so it is dropped.
    always_comb begin
        on      = '0;
        busy_ch = '0;
        wr_hit  = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            on[ch]      = (level[ch] == PWM_MAX) || (pwm_cnt < level[ch]);
            busy_ch[ch] = (level[ch] != target[ch]);
            wr_hit[ch]  = wr_en && (level_sel == SEL_W'(ch));
        end
    end

    // PWM phase counter and the period divider that paces fade steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt  <= '0;
            fade_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (period_end) begin
                fade_cnt <= tick ? '0 : fade_cnt + 1'b1;
            end
        end
    end

    // Level/target update; a write wins over a fade step on the same channel.
    // Steps only happen when level != target, so +/-1 never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                level[ch]  <= '0;
                target[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (wr_hit[ch]) begin
                    target[ch] <= level_in;
                    if (!mode) begin
                        level[ch] <= level_in;
                    end
                end else if (tick && busy_ch[ch]) begin
                    if (level[ch] < target[ch]) begin
                        level[ch] <= level[ch] + 1'b1;
                    end else begin
                        level[ch] <= level[ch] - 1'b1;
                    end
                end
            end
        end
    end

    // Registered output gate: pattern during the on-phase, blank otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= BLANK;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                data_out[ch*DATA_W +: DATA_W] <= on[ch] ? data_in[ch*DATA_W +: DATA_W]
                                                        : BLANK[ch*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Bench for led_pwm_dimmer: cycle model feeding an expected-output queue,
// a table of write vectors checked by measured duty, and hand sequences for
// fades, write/tick collision and reset mid-fade.
module tb_led_pwm_dimmer;

    localparam int CH   = 5;
    localparam int DW   = 8;
    localparam int PB   = 4;
    localparam int SW   = 3;
    localparam int FP   = 4;
    localparam int MAXL = 15;
    localparam int W    = CH * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cs = 1'b0;
    logic          level_we = 1'b0;
    logic [SW-1:0] level_sel = '0;
    logic [PB-1:0] level_in = '0;
    logic          mode = 1'b0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          period_start;
    logic          fade_busy;

    led_pwm_dimmer #(
        .CHANNELS(CH), .DATA_W(DW), .PWM_BITS(PB), .SEL_W(SW), .FADE_PERIODS(FP)
    ) dut (
        .clk(clk), .rst(rst), .cs(cs), .level_we(level_we), .level_sel(level_sel),
        .level_in(level_in), .mode(mode), .data_in(data_in), .data_out(data_out),
        .period_start(period_start), .fade_busy(fade_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    int m_level[CH];
    int m_target[CH];
    int m_pwm = 0;
    int m_fcnt = 0;

    typedef struct {
        bit c;
        bit we;
        int sel;
        int lvl;
        int exp_on;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        for (int c = 0; c < CH; c++) if (m_level[c] != m_target[c]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: predict, queue the expected output, advance the model, compare.
    task automatic step();
        logic [W-1:0] e;
        logic [W-1:0] want;
        bit tk;
        bit on_ph;
        e = '1;
        if (!rst) begin
            for (int c = 0; c < CH; c++) begin
                on_ph = (m_level[c] == MAXL) || (m_pwm < m_level[c]);
                if (on_ph) e[c*DW +: DW] = data_in[c*DW +: DW];
            end
        end
        exp_q.push_back(e);
        if (rst) begin
            m_pwm = 0;
            m_fcnt = 0;
            for (int c = 0; c < CH; c++) begin
                m_level[c] = 0;
                m_target[c] = 0;
            end
        end else begin
            tk = (m_pwm == MAXL) && (m_fcnt == FP - 1);
            if (m_pwm == MAXL) m_fcnt = tk ? 0 : m_fcnt + 1;
            for (int c = 0; c < CH; c++) begin
                if (cs && level_we && int'(level_sel) == c) begin
                    m_target[c] = int'(level_in);
                    if (!mode) m_level[c] = int'(level_in);
                end else if (tk && m_level[c] != m_target[c]) begin
                    m_level[c] += (m_level[c] < m_target[c]) ? 1 : -1;
                end
            end
            m_pwm = (m_pwm + 1) % (MAXL + 1);
        end
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        chk("data_out", data_out, want);
        chk("fade_busy", fade_busy, m_busy());
        chk("period_start", period_start, m_pwm == 0);
    endtask

    task automatic wr(input bit c, input bit we, input int s, input int l, input bit m);
        cs = c;
        level_we = we;
        level_sel = SW'(s);
        level_in = PB'(l);
        mode = m;
        step();
        cs = 1'b0;
        level_we = 1'b0;
    endtask

    task automatic align(input int p);
        for (int i = 0; i < 32 && m_pwm != p; i++) step();
    endtask

    task automatic wait_tick_next();
        for (int i = 0; i < 200 && !(m_pwm == MAXL && m_fcnt == FP - 1); i++) step();
    endtask

    // Count on-cycles of one channel over a full period starting at pwm_cnt==0.
    task automatic measure(input int c, output int cnt);
        cnt = 0;
        for (int i = 0; i < MAXL + 1; i++) begin
            step();
            if (data_out[c*DW +: DW] == data_in[c*DW +: DW]) cnt++;
        end
    endtask

    initial begin
        int cnt, cnt2, prev, mono, bad_seq, bad_other, ps_cnt;
        bit done;
        int hist[16];

        vecs[0] = '{1, 1, 1, 15, 16};
        vecs[1] = '{1, 1, 1, 0, 0};
        vecs[2] = '{1, 1, 1, 6, 6};
        vecs[3] = '{0, 1, 1, 9, 6};
        vecs[4] = '{1, 1, 5, 9, 6};
        vecs[5] = '{1, 1, 7, 9, 6};
        vecs[6] = '{1, 0, 1, 9, 6};
        vecs[7] = '{1, 1, 1, 1, 1};
        vecs[8] = '{1, 1, 1, 14, 14};

        // Reset held three clocks with zero data.
        rst = 1'b1;
        data_in = '0;
        for (int i = 0; i < 3; i++) step();
        chk("reset_data_out", data_out, {W{1'b1}});
        chk("reset_fade_busy", fade_busy, 1'b0);
        chk("reset_period_start", period_start, 1'b1);
        rst = 1'b0;
        ps_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            step();
            if (period_start) ps_cnt++;
        end
        chk("period_start_every_16", ps_cnt, 2);

        data_in = {8'h0F, 8'hC3, 8'h5A, 8'h3C, 8'hA5};

        // Immediate duty 4 on channel 0.
        align(MAXL);
        wr(1, 1, 0, 4, 0);
        bad_seq = 0;
        bad_other = 0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if ((data_out[7:0] == 8'hA5) != (i < 4)) bad_seq++;
            if (data_out[7:0] == 8'hA5) cnt++;
            if (data_out[W-1:8] != {(W-8){1'b1}}) bad_other++;
        end
        chk("ch0_duty4_count", cnt, 4);
        chk("ch0_duty4_phase", bad_seq, 0);
        chk("ch0_other_blank", bad_other, 0);

        // Table of writes on channel 1, judged by measured duty.
        for (int v = 0; v < 9; v++) begin
            align(MAXL);
            wr(vecs[v].c, vecs[v].we, vecs[v].sel, vecs[v].lvl, 0);
            measure(1, cnt);
            chk($sformatf("vec%0d_ch1_duty", v), cnt, vecs[v].exp_on);
        end

        // Fade up on channel 2: 0 -> 3.
        align(MAXL);
        wr(1, 1, 2, 3, 1);
        chk("fade_up_busy_start", fade_busy, 1'b1);
        for (int i = 0; i < 16; i++) hist[i] = 0;
        prev = 0; mono = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            measure(2, cnt);
            if (cnt < prev) mono++;
            prev = cnt;
            hist[cnt]++;
            if (cnt == 3) done = 1;
        end
        chk("fade_up_done", done, 1'b1);
        chk("fade_up_lvl1_periods", hist[1], 4);
        chk("fade_up_lvl2_periods", hist[2], 4);
        chk("fade_up_monotonic", mono, 0);
        chk("fade_up_busy_end", fade_busy, 1'b0);

        // Fade down on channel 2: 3 -> 0.
        align(MAXL);
        wr(1, 1, 2, 0, 1);
        chk("fade_dn_busy_start", fade_busy, 1'b1);
        for (int i = 0; i < 16; i++) hist[i] = 0;
        prev = 15; mono = 0; done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            measure(2, cnt);
            if (cnt > prev) mono++;
            prev = cnt;
            hist[cnt]++;
            if (cnt == 0) done = 1;
        end
        chk("fade_dn_done", done, 1'b1);
        chk("fade_dn_lvl2_periods", hist[2], 4);
        chk("fade_dn_lvl1_periods", hist[1], 4);
        chk("fade_dn_monotonic", mono, 0);
        chk("fade_dn_busy_end", fade_busy, 1'b0);

        // Collision: immediate write to ch2 on the tick clock, ch3 still steps.
        wr(1, 1, 2, 15, 1);
        wr(1, 1, 3, 8, 1);
        wait_tick_next();
        wr(1, 1, 2, 9, 0);
        measure(2, cnt);
        measure(3, cnt2);
        chk("collision_ch2_level9", cnt, 9);
        chk("collision_ch3_stepped", cnt2, 1);
        chk("collision_busy", fade_busy, 1'b1);

        // Reset mid-fade.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midreset_busy", fade_busy, 1'b0);
        chk("midreset_blank", data_out, {W{1'b1}});
        chk("midreset_period_start", period_start, 1'b1);
        measure(2, cnt);
        chk("midreset_ch2_off", cnt, 0);
        measure(3, cnt);
        chk("midreset_ch3_off", cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
